// File: rtl/l2_round_robin_arbiter_pkg.sv
// Shared L2 arbitration constants and types.
package l2_config_and_types;

    localparam int unsigned L2_NUM_PORTS  = 4;
    localparam int unsigned L2_PORT_IDX_W = $clog2(L2_NUM_PORTS);

    typedef logic [L2_PORT_IDX_W-1:0] l2_port_index_t;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/l2_arbitration_interface.sv
// L2 arbitration handshake: requesters drive requests/strobe, the arbiter returns the grant.
interface l2_arbitration_interface
    import l2_config_and_types::*;
#(
    parameter int unsigned NUM_PORTS = L2_NUM_PORTS
) (
    input logic clk,
    input logic rst_n
);

    logic [NUM_PORTS-1:0]         requests;
    logic                         strobe;
    logic [$clog2(NUM_PORTS)-1:0] grantee_i;
    logic [NUM_PORTS-1:0]         grantee_v;
    logic                         grantee_valid;

    modport slave (
        input  clk,
        input  rst_n,
        input  requests,
        input  strobe,
        output grantee_i,
        output grantee_v,
        output grantee_valid
    );

    modport master (
        input  clk,
        input  rst_n,
        output requests,
        output strobe,
        input  grantee_i,
        input  grantee_v,
        input  grantee_valid
    );

endinterface

// File: rtl/l2_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping, via a doubled request vector.
module l2_rr_pick
    import l2_config_and_types::*;
#(
    parameter  int unsigned NUM_PORTS = L2_NUM_PORTS,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] requests,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     pick_i_c,
    output logic [NUM_PORTS-1:0] pick_v_c,
    output logic                 pick_any_c
);

    localparam int unsigned DBL_W = $clog2(2 * NUM_PORTS);

    logic [2*NUM_PORTS-1:0] doubled;
    logic [DBL_W-1:0]       pos;

    assign doubled = {requests, requests};

    // Scan NUM_PORTS positions starting at ptr; the upper copy handles the wrap.
    always_comb begin
        pick_i_c   = '0;
        pick_any_c = 1'b0;
        pos        = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            pos = DBL_W'(ptr) + DBL_W'(j);
            if (!pick_any_c && doubled[pos]) begin
                pick_any_c = 1'b1;
                pick_i_c   = (pos >= DBL_W'(NUM_PORTS)) ? IDX_W'(pos - DBL_W'(NUM_PORTS))
                                                        : IDX_W'(pos);
            end
        end
    end

    // One-hot form of the pick, zero when nothing requests.
    always_comb begin
        pick_v_c = '0;
        if (pick_any_c) begin
            pick_v_c = NUM_PORTS'(1) << pick_i_c;
        end
    end

endmodule

// File: rtl/l2_round_robin_arbiter.sv
// Round-robin L2 arbiter responder: registered grant held until strobed.
module l2_round_robin_arbiter
    import l2_config_and_types::*;
#(
    parameter  int unsigned NUM_PORTS = L2_NUM_PORTS,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] requests,
    input  logic                 strobe,
    output logic [IDX_W-1:0]     grantee_i,
    output logic [NUM_PORTS-1:0] grantee_v,
    output logic                 grantee_valid
);

    if (NUM_PORTS < 2) begin : g_bad_num_ports
        $error("l2_round_robin_arbiter: NUM_PORTS must be at least 2");
    end

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_after_c;
    logic [IDX_W-1:0]     ptr_sel_c;
    logic                 consume_c;
    logic [IDX_W-1:0]     pick_i_c;
    logic [NUM_PORTS-1:0] pick_v_c;
    logic                 pick_any_c;

    // Pointer after a consumed grant: the port after the grantee, so the grantee drops to lowest priority.
    always_comb begin
        consume_c   = (state == ARB_GRANTED) && strobe;
        ptr_after_c = (grantee_i == IDX_W'(NUM_PORTS - 1)) ? '0 : grantee_i + IDX_W'(1);
        ptr_sel_c   = consume_c ? ptr_after_c : ptr;
    end

    l2_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .requests   (requests),
        .ptr        (ptr_sel_c),
        .pick_i_c   (pick_i_c),
        .pick_v_c   (pick_v_c),
        .pick_any_c (pick_any_c)
    );

    // Grant FSM: take a pick in IDLE, hold while GRANTED, re-pick or drop on strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            ptr           <= '0;
            grantee_i     <= '0;
            grantee_v     <= '0;
            grantee_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any_c) begin
                        grantee_i     <= pick_i_c;
                        grantee_v     <= pick_v_c;
                        grantee_valid <= 1'b1;
                        state         <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (consume_c) begin
                        ptr <= ptr_after_c;
                        if (pick_any_c) begin
                            grantee_i <= pick_i_c;
                            grantee_v <= pick_v_c;
                        end else begin
                            grantee_v     <= '0;
                            grantee_valid <= 1'b0;
                            state         <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_round_robin_arbiter.sv
// Directed bench for l2_round_robin_arbiter with NUM_PORTS=4.
module tb_l2_round_robin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] requests;
    logic       strobe;
    logic [1:0] grantee_i;
    logic [3:0] grantee_v;
    logic       grantee_valid;

    int vectors;
    int miscompares;

    l2_round_robin_arbiter #(
        .NUM_PORTS (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .requests      (requests),
        .strobe        (strobe),
        .grantee_i     (grantee_i),
        .grantee_v     (grantee_v),
        .grantee_valid (grantee_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] i, input logic [3:0] v,
                             input logic valid);
        chk({tag, ".i"},     32'(grantee_i),     32'(i));
        chk({tag, ".v"},     32'(grantee_v),     32'(v));
        chk({tag, ".valid"}, 32'(grantee_valid), 32'(valid));
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        requests = 4'b0000;
        strobe   = 1'b0;
        rst_n    = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Requesters must keep the granted request up until it is strobed.
    always @(negedge clk) begin
        if (rst_n && grantee_valid && !strobe) begin
            chk("no_withdraw", 32'(requests[grantee_i]), 32'd1);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        requests    = 4'b1111;
        strobe      = 1'b0;

        // Reset with all requests held.
        cyc();
        chk_grant("rst0", 2'd0, 4'b0000, 1'b0);
        cyc();
        chk_grant("rst1", 2'd0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        chk_grant("rel", 2'd0, 4'b0000, 1'b0);
        cyc();
        chk_grant("first", 2'd0, 4'b0001, 1'b1);

        // Back-to-back round robin with strobe held high.
        strobe = 1'b1;
        cyc();
        chk_grant("rr1", 2'd1, 4'b0010, 1'b1);
        cyc();
        chk_grant("rr2", 2'd2, 4'b0100, 1'b1);
        cyc();
        chk_grant("rr3", 2'd3, 4'b1000, 1'b1);
        cyc();
        chk_grant("rr0", 2'd0, 4'b0001, 1'b1);
        strobe = 1'b0;
        cyc();
        chk_grant("rr_hold", 2'd0, 4'b0001, 1'b1);

        // Grant to port 2 held across requests changes without strobe.
        do_reset();
        requests = 4'b0100;
        cyc();
        chk_grant("g2", 2'd2, 4'b0100, 1'b1);
        requests = 4'b1111;
        cyc();
        chk_grant("hold_a", 2'd2, 4'b0100, 1'b1);
        requests = 4'b0110;
        cyc();
        chk_grant("hold_b", 2'd2, 4'b0100, 1'b1);
        requests = 4'b1101;
        cyc();
        chk_grant("hold_c", 2'd2, 4'b0100, 1'b1);
        requests = 4'b0111;
        cyc();
        chk_grant("hold_d", 2'd2, 4'b0100, 1'b1);
        requests = 4'b0100;
        cyc();
        chk_grant("hold_e", 2'd2, 4'b0100, 1'b1);

        // Strobe with no requests leaves ptr=3 and goes idle keeping grantee_i.
        requests = 4'b0000;
        strobe   = 1'b1;
        cyc();
        chk_grant("idle_p3", 2'd2, 4'b0000, 1'b0);
        strobe   = 1'b0;
        requests = 4'b0011;
        cyc();
        chk_grant("p3_g0", 2'd0, 4'b0001, 1'b1);
        strobe = 1'b1;
        cyc();
        chk_grant("p3_g1", 2'd1, 4'b0010, 1'b1);
        requests = 4'b0000;
        cyc();
        chk_grant("p3_idle", 2'd1, 4'b0000, 1'b0);
        // ptr is now 2: of ports 3 and 0, port 3 comes first.
        strobe   = 1'b0;
        requests = 4'b1001;
        cyc();
        chk_grant("p2_g3", 2'd3, 4'b1000, 1'b1);

        // Sole requester is regranted; otherwise the previous grantee yields.
        do_reset();
        requests = 4'b0010;
        cyc();
        chk_grant("solo_g1", 2'd1, 4'b0010, 1'b1);
        strobe = 1'b1;
        cyc();
        chk_grant("solo_re", 2'd1, 4'b0010, 1'b1);
        requests = 4'b0011;
        cyc();
        chk_grant("yield_g0", 2'd0, 4'b0001, 1'b1);
        strobe = 1'b0;

        // Strobe in IDLE leaves ptr at 0: ports 0 and 3 requesting picks 0.
        do_reset();
        strobe = 1'b1;
        cyc();
        chk_grant("idle_stb", 2'd0, 4'b0000, 1'b0);
        strobe   = 1'b0;
        requests = 4'b1001;
        cyc();
        chk_grant("idle_ptr", 2'd0, 4'b0001, 1'b1);

        // Strobe pulsed in IDLE then a request on port 3.
        do_reset();
        strobe = 1'b1;
        cyc();
        chk_grant("idle_stb2", 2'd0, 4'b0000, 1'b0);
        strobe   = 1'b0;
        requests = 4'b1000;
        chk_grant("lat0", 2'd0, 4'b0000, 1'b0);
        cyc();
        chk_grant("g3", 2'd3, 4'b1000, 1'b1);

        // Asynchronous reset while granted, checked before the next clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk_grant("async_rst", 2'd0, 4'b0000, 1'b0);
        requests = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_grant("post_rst", 2'd0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_round_robin_arbiter.md
# l2_round_robin_arbiter

Responder end of the L2 arbitration handshake: consumes the per-port `requests` vector and the `strobe` from the L2 request path, and drives the registered grant (`grantee_i`, `grantee_v`, `grantee_valid`) back to the requesters. It sits at the front of the L2 arbiter and selects which L2 port's request is forwarded next. Selection is round-robin, and a grant is held stable until the consumer strobes it.

## Interface
Parameters:
- `NUM_PORTS`, default `L2_NUM_PORTS`: number of requesting ports; must be ≥ 2 (elaboration-time assertion).

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `requests`  input  NUM_PORTS  per-port request; bit k = port k has a pending request.
- `strobe`  input  1  grant consumed this cycle; meaningful only while `grantee_valid`=1.
- `grantee_i`  output  $clog2(NUM_PORTS)  index of the granted port.
- `grantee_v`  output  NUM_PORTS  one-hot form of `grantee_i`; all zero when no grant is held.
- `grantee_valid`  output  1  a grant is held.

The port set matches the `slave` modport of `l2_arbitration_interface`. The top level connects through that modport.

## Operation
- State machine, two states:
  - IDLE: no grant held.
  - GRANTED: grant held, outputs frozen.
- Priority pointer `ptr`, range 0..NUM_PORTS-1. It names the highest-priority port.
- Pick function: first set bit of `requests`, searching ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1. The search wraps explicitly, so NUM_PORTS need not be a power of two.
- IDLE:
  - `requests`≠0 → register the pick into `grantee_i` and `grantee_v`, set `grantee_valid`, go to GRANTED.
  - Otherwise stay in IDLE.
- GRANTED without `strobe`:
  - All outputs hold, regardless of changes on `requests`.
  - A withdrawn request does not revoke the grant. Requesters must not withdraw; the bench asserts this.
- GRANTED with `strobe`:
  - `ptr` ← (grantee_i+1) mod NUM_PORTS.
  - The pick is evaluated in the same cycle using the updated ptr and the current `requests`.
  - Nonzero pick → register the new grant and stay in GRANTED (back-to-back grants).
  - Zero pick → go to IDLE, clear `grantee_v`, clear `grantee_valid`, keep `grantee_i`.
- `strobe` in IDLE is ignored: no state change, no `ptr` change.
- The previous grantee is lowest priority after its strobe. It is regranted only when no other port requests.
- Invariants:
  - `grantee_v` = onehot(`grantee_i`) whenever `grantee_valid`=1.
  - `grantee_v`=0 whenever `grantee_valid`=0.

## Timing
- Reset (asynchronous assert, synchronous release): IDLE, `ptr`=0, `grantee_i`=0, `grantee_v`=0, `grantee_valid`=0.
- Reset mid-grant drops the grant immediately. No strobe is owed afterwards.
- Latency:
  - Request seen in IDLE at cycle t → `grantee_valid`=1 at t+1.
  - Strobe at cycle t with another request pending → new grant visible at t+1. `grantee_valid` stays 1, so there is no bubble.
- All outputs are registered. There is no combinational path from `requests` or `strobe` to any output.
- Sustained throughput: one grant per cycle when `strobe` is held high and requests remain pending.

## Structure
- The following constants live in `l2_config_and_types`: `L2_NUM_PORTS` and a `l2_port_index_t` typedef of width $clog2(L2_NUM_PORTS).
- Sub-module `l2_rr_pick` (combinational): inputs `requests` and `ptr`; outputs pick index, pick one-hot and any-valid. Implemented as a doubled-vector priority encoder.
- The top module holds the FSM, `ptr` and the output registers.

## Test plan
All scenarios use NUM_PORTS=4.
- Reset with `requests`=4'b1111 held → all outputs 0 during reset. First cycle after release: `requests` sampled. Following cycle: `grantee_i`=0, `grantee_v`=4'b0001, `grantee_valid`=1.
- `requests`=4'b1111 with `strobe` high every cycle → grants 0,1,2,3,0 on consecutive cycles, with no bubbles.
- Grant to port 2 held, `strobe` low for 5 cycles while `requests` toggles → `grantee_i`=2 and `grantee_v`=4'b0100 are stable for all 5 cycles.
- `ptr`=3, `requests`=4'b0011 → grant 0; after strobe, grant 1; after next strobe with `requests`=4'b0000 → IDLE, `grantee_valid`=0, `grantee_v`=0.
- Port 1 granted, strobe, only port 1 still requesting → port 1 regranted on the next cycle.
- `strobe` pulsed in IDLE, then `requests`=4'b1000 → no `ptr` change, grant 3 one cycle later. Separately, `rst_n` dropped while GRANTED → `grantee_valid`=0 asynchronously, before the next clock edge.
